// File: rtl/dsm_pkg.sv
// dsm_pkg -- shared constants and helpers for the 2nd-order delta-sigma
// modulator (dsm2_modulator) and its optional dither LFSR (dsm_lfsr).
//   DEF_VREF / DEF_INT_LIMIT : default DAC feedback magnitude and integrator clamp
//   ovl_cnt_t                : default overload-counter type
//   LFSR_SEED / LFSR_TAPS    : dither LFSR reset value and Fibonacci tap mask
//   sat_real()               : symmetric clamp of a real value to [-limit, +limit]
package dsm_pkg;

  localparam real DEF_VREF      = 1.0;
  localparam real DEF_INT_LIMIT = 4.0;

  typedef logic [15:0] ovl_cnt_t;

  // Taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic real sat_real(input real x, input real limit);
    if (x > limit) begin
      return limit;
    end else if (x < -limit) begin
      return -limit;
    end
    return x;
  endfunction

endpackage

// File: rtl/dsm_lfsr.sv
// dsm_lfsr -- 16-bit Fibonacci LFSR that advances once per modulator sample.
// Supplies the dither source for dsm2_modulator when DSM_DITHER_EN is defined.
// Ports:
//   clk     in   modulator clock
//   reset   in   synchronous active-high reset, reloads LFSR_SEED
//   advance in   shift once on this clock (the sample strobe)
//   lfsr    out  current 16-bit LFSR state
module dsm_lfsr
  import dsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] lfsr
);

  logic [15:0] lfsrReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsrReg <= LFSR_SEED;
    end else if (advance) begin
      // Feedback is the XOR of the tapped bits, shifted in at the LSB.
      lfsrReg <= {lfsrReg[14:0], ^(lfsrReg & LFSR_TAPS)};
    end
  end

  assign lfsr = lfsrReg;

endmodule

// File: rtl/dsm2_modulator.sv
// dsm2_modulator -- behavioural 2nd-order Boser-Wooley delta-sigma modulator
// with a 1-bit quantizer, real-valued input and integrator states.
// Optional feature macro: DSM_DITHER_EN adds LFSR dither at the quantizer input
// (and the DITHER_AMP parameter); without it the output is fully deterministic.
// Ports:
//   clk        in   modulator clock
//   reset      in   synchronous active-high reset (highest priority)
//   enable     in   1 = run; 0 = hold state, divider forced to 0
//   analog_in  in   real input, nominal +/-VREF, sampled only on the strobe
//   ovl_clear  in   clears ovl_flag / ovl_count (a simultaneous clamp wins)
//   dout       out  bitstream, 1 = +VREF feedback
//   dout_valid out  one-clock pulse on each dout update
//   ovl_flag   out  sticky integrator-clamp indicator
//   ovl_count  out  saturating count of strobes that clamped
module dsm2_modulator
  import dsm_pkg::*;
#(
  parameter int  CLK_DIV   = 4,
  parameter real VREF      = DEF_VREF,
  parameter real A1        = 0.5,
  parameter real A2        = 0.5,
  parameter real INT_LIMIT = DEF_INT_LIMIT,
  parameter int  OVL_CNT_W = $bits(ovl_cnt_t)
`ifdef DSM_DITHER_EN
  ,
  parameter real DITHER_AMP = 0.01
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  real                  analog_in,
  input  logic                 ovl_clear,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 ovl_flag,
  output logic [OVL_CNT_W-1:0] ovl_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     divCntReg, divCntNext;
  real                  v1Reg, v2Reg;
  real                  v1Raw, v2Raw, v1Next, v2Next, fb, dither;
  logic                 doutReg, doutValidReg, ovlFlagReg, ovlFlagNext;
  logic [OVL_CNT_W-1:0] ovlCountReg, ovlCountNext;
  logic                 strobe, yPos, clampHit;

`ifdef DSM_DITHER_EN
  logic [15:0] lfsrVal;

  dsm_lfsr uLfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (strobe),
    .lfsr    (lfsrVal)
  );

  // Map the LFSR state onto [-DITHER_AMP, +DITHER_AMP].
  always_comb begin
    dither = DITHER_AMP * (2.0 * $itor(lfsrVal) / 65535.0 - 1.0);
  end
`else
  always_comb begin
    dither = 0.0;
  end
`endif

  // Divider, quantizer and integrator updates, all from the registered states.
  always_comb begin
    strobe = enable && (divCntReg == DIV_LAST);

    divCntNext = divCntReg;
    if (!enable || divCntReg == DIV_LAST) begin
      divCntNext = '0;
    end else begin
      divCntNext = divCntReg + DIV_W'(1);
    end

    yPos  = ((v2Reg + dither) >= 0.0);
    fb    = yPos ? VREF : -VREF;
    v1Raw = v1Reg + A1 * (analog_in - fb);
    v2Raw = v2Reg + A2 * (v1Reg - fb);
    v1Next = sat_real(v1Raw, INT_LIMIT);
    v2Next = sat_real(v2Raw, INT_LIMIT);
    clampHit = (v1Raw > INT_LIMIT) || (v1Raw < -INT_LIMIT) ||
               (v2Raw > INT_LIMIT) || (v2Raw < -INT_LIMIT);
  end

  // Overload tracking: a clamp on this strobe beats a simultaneous clear.
  always_comb begin
    ovlFlagNext  = ovlFlagReg;
    ovlCountNext = ovlCountReg;
    if (strobe && clampHit) begin
      ovlFlagNext = 1'b1;
      if (ovl_clear) begin
        ovlCountNext = OVL_CNT_W'(1);
      end else if (ovlCountReg != '1) begin
        ovlCountNext = ovlCountReg + OVL_CNT_W'(1);
      end
    end else if (ovl_clear) begin
      ovlFlagNext  = 1'b0;
      ovlCountNext = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divCntReg    <= '0;
      v1Reg        <= 0.0;
      v2Reg        <= 0.0;
      doutReg      <= 1'b0;
      doutValidReg <= 1'b0;
      ovlFlagReg   <= 1'b0;
      ovlCountReg  <= '0;
    end else begin
      divCntReg    <= divCntNext;
      doutValidReg <= strobe;
      if (strobe) begin
        v1Reg   <= v1Next;
        v2Reg   <= v2Next;
        doutReg <= yPos;
      end
      ovlFlagReg  <= ovlFlagNext;
      ovlCountReg <= ovlCountNext;
    end
  end

  assign dout       = doutReg;
  assign dout_valid = doutValidReg;
  assign ovl_flag   = ovlFlagReg;
  assign ovl_count  = ovlCountReg;

endmodule

// File: tb/tb_dsm2_modulator.sv
// Self-checking bench for dsm2_modulator: two instances (CLK_DIV = 1 and 4)
// share stimulus; a difference-equation model predicts every output each cycle.
module tb_dsm2_modulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, ovl_clear;
  real  analogIn;

  logic        dout1, valid1, flag1, dout4, valid4, flag4;
  logic [15:0] cnt1, cnt4;

  dsm2_modulator #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .analog_in(analogIn),
    .ovl_clear(ovl_clear), .dout(dout1), .dout_valid(valid1),
    .ovl_flag(flag1), .ovl_count(cnt1)
  );

  dsm2_modulator #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .analog_in(analogIn),
    .ovl_clear(ovl_clear), .dout(dout4), .dout_valid(valid4),
    .ovl_flag(flag4), .ovl_count(cnt4)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input longint act,
                            input longint lo, input longint hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  divOf[2] = '{1, 4};
  real mV1[2], mV2[2];
  int  mRun[2];       // consecutive enabled clocks since reset/disable
  bit  mDout[2], mValid[2], mFlag[2];
  int  mCnt[2];

  task automatic modelStep(input int i);
    bit  sample, hit;
    real y, r1, r2;
    if (reset) begin
      mV1[i] = 0.0; mV2[i] = 0.0; mRun[i] = 0;
      mDout[i] = 0; mValid[i] = 0; mFlag[i] = 0; mCnt[i] = 0;
    end else begin
      sample = enable && (((mRun[i] + 1) % divOf[i]) == 0);
      mRun[i] = enable ? mRun[i] + 1 : 0;
      mValid[i] = sample;
      hit = 0;
      if (sample) begin
        y  = (mV2[i] >= 0.0) ? 1.0 : -1.0;
        r1 = mV1[i] + 0.5 * (analogIn - y);
        r2 = mV2[i] + 0.5 * (mV1[i] - y);
        hit = (r1 > 4.0) || (r1 < -4.0) || (r2 > 4.0) || (r2 < -4.0);
        mV1[i] = (r1 > 4.0) ? 4.0 : ((r1 < -4.0) ? -4.0 : r1);
        mV2[i] = (r2 > 4.0) ? 4.0 : ((r2 < -4.0) ? -4.0 : r2);
        mDout[i] = (y > 0.0);
      end
      if (sample && hit) begin
        mFlag[i] = 1;
        mCnt[i]  = ovl_clear ? 1 : ((mCnt[i] < 65535) ? mCnt[i] + 1 : 65535);
      end else if (ovl_clear) begin
        mFlag[i] = 0;
        mCnt[i]  = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep(0);
    modelStep(1);
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      check("div1_dout",  dout1,  mDout[0]);
      check("div1_valid", valid1, mValid[0]);
      check("div1_flag",  flag1,  mFlag[0]);
      check("div1_count", cnt1,   mCnt[0]);
      check("div4_dout",  dout4,  mDout[1]);
      check("div4_valid", valid4, mValid[1]);
      check("div4_flag",  flag4,  mFlag[1]);
      check("div4_count", cnt4,   mCnt[1]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  bit  stream1[$];
  bit  stream2[$];
  int  ones, k, c0, bad, pulses, changed;
  longint sum;
  bit  d0;
  real level;

  initial begin
    reset = 1'b1; enable = 1'b0; analogIn = 0.0; ovl_clear = 1'b0;
    tick();
    checkEn = 1;
    tick();
    check("reset_dout", dout1, 0);
    check("reset_valid", valid1, 0);
    check("reset_count", cnt4, 0);

    // Zero input: hand-derived limit cycle 1,0,0,1 and 50% density.
    reset = 1'b0; enable = 1'b1;
    ones = 0;
    for (int n = 0; n < 16 + 1024; n++) begin
      tick();
      if (n < 64) stream1.push_back(dout1);
      if (n >= 16) ones += int'(dout1);
    end
    check("zero_bit0", stream1[0], 1);
    check("zero_bit1", stream1[1], 0);
    check("zero_bit2", stream1[2], 0);
    check("zero_bit3", stream1[3], 1);
    checkRange("zero_ones", ones, 510, 514);
    check("zero_ovl_count", cnt1, 0);

    // DC +/-0.5.
    analogIn = 0.5;
    ones = 0;
    for (int n = 0; n < 16 + 1024; n++) begin
      tick();
      if (n >= 16) ones += int'(dout1);
    end
    checkRange("dc_pos_ones", ones, 764, 772);
    analogIn = -0.5;
    ones = 0;
    for (int n = 0; n < 16 + 1024; n++) begin
      tick();
      if (n >= 16) ones += int'(dout1);
    end
    checkRange("dc_neg_ones", ones, 252, 260);

    // Sine, 0.9 amplitude, 1.0231 kHz at 1 MHz sample rate.
    sum = 0;
    for (int n = 0; n < 65536; n++) begin
      analogIn = 0.9 * $sin(2.0 * 3.141592653589793 * 1023.1 * n / 1.0e6);
      tick();
      sum += dout1 ? 1 : -1;
    end
    checkRange("sine_mean_x65536", sum, -655, 655);

    // Mid-run reset, then replay of the zero-input stream.
    analogIn = 0.37;
    for (int n = 0; n < 13; n++) tick();
    reset = 1'b1;
    tick();
    check("midreset_dout", dout1, 0);
    check("midreset_valid", valid1, 0);
    check("midreset_flag", flag1, 0);
    check("midreset_count", cnt1, 0);
    reset = 1'b0; analogIn = 0.0;
    for (int n = 0; n < 64; n++) begin
      tick();
      stream2.push_back(dout1);
    end
    bad = 0;
    for (int n = 0; n < 64; n++) if (stream1[n] != stream2[n]) bad++;
    check("replay_diffs", bad, 0);

    // Overload at 1.5 DC.
    reset = 1'b1;
    tick();
    reset = 1'b0; analogIn = 1.5;
    k = 0;
    while (!flag1 && k < 40) begin
      tick();
      k++;
    end
    checkRange("ovl_strobes_to_flag", k, 1, 20);
    for (int n = 0; n < 10; n++) tick();
    c0 = int'(cnt1);
    for (int n = 0; n < 5; n++) tick();
    check("ovl_count_step", cnt1, c0 + 5);
    ovl_clear = 1'b1;
    tick();
    ovl_clear = 1'b0;
    check("ovl_clear_on_clamp_count", cnt1, 1);
    check("ovl_clear_on_clamp_flag", flag1, 1);
    tick();
    check("ovl_count_after_clear", cnt1, 2);
    enable = 1'b0; ovl_clear = 1'b1;
    tick();
    ovl_clear = 1'b0;
    check("ovl_clear_alone_count", cnt1, 0);
    check("ovl_clear_alone_flag", flag1, 0);

    // CLK_DIV = 4 strobe spacing, enable hold, re-enable latency.
    reset = 1'b1;
    tick();
    reset = 1'b0; enable = 1'b1; analogIn = 0.3;
    bad = 0; pulses = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      pulses += int'(valid4);
      if (valid4 != ((t % 4) == 0)) bad++;
    end
    check("div4_pattern_errors", bad, 0);
    check("div4_pulses", pulses, 10);
    d0 = dout4; enable = 1'b0; pulses = 0; changed = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      pulses += int'(valid4);
      if (dout4 != d0) changed++;
    end
    check("disabled_pulses", pulses, 0);
    check("disabled_dout_changes", changed, 0);
    enable = 1'b1; k = 0;
    do begin
      tick();
      k++;
    end while (!valid4 && k < 12);
    check("reenable_latency", k, 4);

    // Randomized levels, enable gaps, clears, overload bursts, resets.
    level = 0.0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 11) == 0)
        level = ($urandom_range(0, 7) == 0) ? 1.7
                : ($itor($urandom_range(0, 1900)) - 950.0) / 1000.0;
      analogIn  = level + ($itor($urandom_range(0, 100)) - 50.0) / 1000.0;
      enable    = ($urandom_range(0, 19) != 0);
      ovl_clear = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0; ovl_clear = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
